// File: rtl/demux_4s_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux_4s_stream_pkg
//   Shared definitions for the 1-to-4 stream demultiplexer:
//   lane select encodings, lane count and a constant clog2 helper.
// -----------------------------------------------------------------------------
package demux_4s_stream_pkg;

  localparam int NUM_LANES = 4;

  // Lane select encoding carried on the 2-bit 's' input.
  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : demux_4s_stream_pkg

// File: rtl/demux_lane_fifo.sv
// -----------------------------------------------------------------------------
// demux_lane_fifo
//   Private per-lane FIFO of the stream demultiplexer. First-word
//   latency is one cycle: a word written at edge N is the head after N.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     push       in   write push_data (ignored while full)
//     push_data  in   WIDTH-bit word to store
//     pop        in   retire the head entry (ignored while empty)
//     head_data  out  oldest stored word
//     count      out  number of stored words, 0..DEPTH
//     full       out  count == DEPTH
//     empty      out  count == 0
// -----------------------------------------------------------------------------
module demux_lane_fifo
  import demux_4s_stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full lane refuses a push even when it pops in the same cycle, so the
  // count can never exceed DEPTH or drop below zero.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem[rd_ptr];

  // NOTE: storage is reset too, so an empty lane presents 0 instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of two: wraps naturally
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule : demux_lane_fifo

// File: rtl/demux_4s_stream.sv
// -----------------------------------------------------------------------------
// demux_4s_stream
//   1-to-4 stream demultiplexer. One valid/ready input stream is steered by
//   's' to one of four lanes, each with a private FIFO so a stalled consumer
//   only blocks words bound for its own lane.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   producer has a word
//     in_ready   out  selected lane has room (depends on s and lane state only)
//     in_data    in   WIDTH-bit word to route
//     s          in   destination lane 0..3
//     out_valid  out  bit i: lane i has a head word
//     out_ready  in   bit i: consumer i takes the head word
//     out_data   out  lane i head at [i*WIDTH +: WIDTH]
//     lane_full  out  bit i: lane i holds DEPTH words
// -----------------------------------------------------------------------------
module demux_4s_stream
  import demux_4s_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 s,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]       lane_full
);

  localparam int CW = clog2(DEPTH) + 1;

  lane_e                sel;
  logic [NUM_LANES-1:0] push_vec;
  logic [NUM_LANES-1:0] pop_vec;
  logic [NUM_LANES-1:0] full_vec;
  logic [NUM_LANES-1:0] empty_vec;
  logic [CW-1:0]        lane_count [NUM_LANES];

  assign sel = lane_e'(s);

  // Readiness comes only from registered lane state, never from out_ready,
  // so the producer sees no combinational path through the consumers.
  assign in_ready  = !full_vec[sel];
  assign lane_full = full_vec;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign push_vec[i]  = in_valid && in_ready && (sel == lane_e'(i));
    assign pop_vec[i]   = out_ready[i] && !empty_vec[i];
    assign out_valid[i] = (lane_count[i] != '0);

    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_vec[i]),
      .push_data (in_data),
      .pop       (pop_vec[i]),
      .head_data (out_data[i*WIDTH +: WIDTH]),
      .count     (lane_count[i]),
      .full      (full_vec[i]),
      .empty     (empty_vec[i])
    );
  end

endmodule : demux_4s_stream

// File: doc/demux_4s_stream.md
Name: demux_4s_stream

Overview:
- 1-to-4 stream demultiplexer: inverse of the 2-bit-select 4:1 data mux.
- Accepts one WIDTH-bit word per handshake on a single valid/ready input and steers it by a 2-bit select to one of four output lanes.
- Each lane has a private 2-entry FIFO, so a stalled lane does not block words bound for other lanes.
- Sits between a single producer (e.g. ALU/regfile write path) and four independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 2, entries per lane FIFO (power of two, at least 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  demux can accept the word on the selected lane.
- in_data  input  WIDTH  word to route.
- s  input  2  destination lane: 00→0, 01→1, 10→2, 11→3.
- out_valid  output  4  bit i: lane i head word valid.
- out_ready  input  4  bit i: consumer i accepts the head word.
- out_data  output  4*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
- lane_full  output  4  bit i: lane i holds DEPTH words.

Behaviour:
- Reset (async assert, sync-safe release):
  - all lane counts and read/write pointers go to 0.
  - out_valid=0, lane_full=0, out_data=0.
  - in_ready reflects empty lanes, so it reads 1 while in reset.
- in_ready = !lane_full[s]. This is purely combinational from s and the registered counts. There is no combinational path from out_ready to in_ready.
- Push: in_valid && in_ready at a clk edge. in_data is written to lane s, and that lane's write pointer and count are incremented.
  - in_valid and in_data may change freely while in_ready=0. Nothing is written.
- Pop on lane i: out_valid[i] && out_ready[i] at a clk edge. Lane i's read pointer is incremented and its count decremented.
- Latency:
  - A word pushed at edge N appears on out_valid/out_data of its lane after edge N (1 cycle). It is not visible in the same cycle.
  - Per-lane order is FIFO.
  - There is no ordering guarantee across lanes.
- Outputs per lane:
  - out_valid[i] = (count_i != 0).
  - out_data for lane i = the head entry. It holds stable while out_valid[i]=1 and out_ready[i]=0.
  - When a lane is empty, its out_data is don't-care but must not be X in simulation after reset. Storage is reset to 0.
- Simultaneous push and pop on the same lane:
  - count unchanged.
  - both pointers advance.
  - this is legal at any count below DEPTH.
  - When the lane is full, the push is refused (in_ready=0) even if the lane pops that cycle.
- Simultaneous pops on several lanes in one cycle are independent and all take effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and saturates by construction (never above DEPTH, never below 0).
- out_ready[i] asserted while lane i is empty: ignored, no state change.
- Reset mid-operation: all buffered words are discarded immediately, with no drain.

Decomposition:
- Shared package (or `include header) holds:
  - lane select encodings LANE0..LANE3 = 2'd0..2'd3.
  - NUM_LANES = 4.
  - a clog2 helper function.
- Sub-module demux_lane_fifo (WIDTH, DEPTH):
  - ports clk, rst_n, push, push_data, pop, head_data, count, full, empty.
  - instantiated 4 times via generate.
- The top level contains only select decode, the in_ready mux, and output packing.

Test Plan:
- Reset: hold rst_n=0 with random inputs → out_valid=4'b0000, lane_full=0, in_ready=1. Release; state unchanged.
- Routing: push 8'hA0,8'hA1,8'hA2,8'hA3 with s=0,1,2,3 and out_ready=0 → after 4 edges out_valid=4'b1111 and lane i out_data = 8'hA0+i.
- Full and backpressure:
  - push 8'h11, 8'h22, 8'h33 to lane 2 with out_ready[2]=0 → the third push sees in_ready=0, lane_full[2]=1.
  - s=1 in the same cycle gives in_ready=1.
  - then out_ready[2]=1 yields 8'h11 then 8'h22, then out_valid[2]=0.
- Concurrent push and pop: lane 0 count=1 holding 8'h05; push 8'h06 to s=0 with out_ready[0]=1 → 8'h05 consumed, count stays 1, head becomes 8'h06.
- Full-lane refusal: lane 3 full, out_ready[3]=1, push to s=3 → in_ready=0, word not written. Next cycle count=1, in_ready=1.
- Async reset mid-stream: lanes 0 and 2 hold data; pulse rst_n low between edges → out_valid drops to 0 without waiting for clk, and no stale words are delivered after release.
